// File: rtl/sprite_dma_if.sv
// Bus bundle for the sprite DMA engine: CPU write snoop, work RAM read port,
// SPRAM write port and the CPU stall/status lines.
interface sprite_dma_if;
  logic        cpu_wr_en;
  logic [15:0] cpu_wr_addr;
  logic [7:0]  cpu_wr_data;
  logic [15:0] mem_rd_addr;
  logic [7:0]  mem_rd_data;
  logic        spram_wr_en;
  logic [7:0]  spram_wr_addr;
  logic [7:0]  spram_wr_data;
  logic        cpu_stall;
  logic        busy;
  logic        done;

  // DMA engine side
  modport slave (
    input  cpu_wr_en, cpu_wr_addr, cpu_wr_data, mem_rd_data,
    output mem_rd_addr, spram_wr_en, spram_wr_addr, spram_wr_data,
    output cpu_stall, busy, done
  );

  // CPU / memory / SPRAM side
  modport master (
    output cpu_wr_en, cpu_wr_addr, cpu_wr_data, mem_rd_data,
    input  mem_rd_addr, spram_wr_en, spram_wr_addr, spram_wr_data,
    input  cpu_stall, busy, done
  );
endinterface

// File: rtl/sprite_dma.sv
// Sprite-attribute DMA: a CPU write to the DMA register copies the 256-byte
// page {page,00..FF} into SPRAM starting at the latched OAM offset, with the
// CPU stalled for the whole copy. Reads alternate with writes because the
// work RAM returns data one cycle after the address.
module sprite_dma #(
  parameter logic [15:0] DMA_REG      = 16'h4014,
  parameter logic [15:0] OAM_ADDR_REG = 16'h2003
) (
  input  logic         clk,
  input  logic         rst,
  sprite_dma_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] page;
  logic [7:0] oam_addr;
  logic [7:0] idx;
  logic       parity;
  logic       trigger;
  logic       oam_load;
  logic [7:0] dst_addr;

  // Register writes are only honoured while idle; a busy engine ignores them.
  assign trigger  = (state == IDLE) && bus.cpu_wr_en && (bus.cpu_wr_addr == DMA_REG);
  assign oam_load = (state == IDLE) && bus.cpu_wr_en && (bus.cpu_wr_addr == OAM_ADDR_REG);
  assign dst_addr = oam_addr + idx;

  // Source address comes straight from registers, so it never leaves the page.
  assign bus.mem_rd_addr   = {page, idx};
  assign bus.spram_wr_data = bus.mem_rd_data;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath registers: free-running parity, offset latch, page latch, byte counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity   <= 1'b0;
      page     <= 8'h00;
      oam_addr <= 8'h00;
      idx      <= 8'h00;
    end else begin
      parity <= ~parity;
      if (oam_load) oam_addr <= bus.cpu_wr_data;
      if (trigger) begin
        page <= bus.cpu_wr_data;
        idx  <= 8'h00;
      end else if ((state == WRITE) && (idx != 8'hFF)) begin
        idx <= idx + 8'h01;
      end
    end
  end

  // Next-state and output decode; HALT inserts ALIGN when parity is odd.
  always_comb begin
    state_nxt         = state;
    bus.spram_wr_en   = 1'b0;
    bus.spram_wr_addr = 8'h00;
    bus.cpu_stall     = 1'b0;
    bus.busy          = 1'b1;
    bus.done          = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (trigger) state_nxt = HALT;
      end
      HALT: begin
        bus.cpu_stall = 1'b1;
        state_nxt     = parity ? ALIGN : READ;
      end
      ALIGN: begin
        bus.cpu_stall = 1'b1;
        state_nxt     = READ;
      end
      READ: begin
        bus.cpu_stall = 1'b1;
        state_nxt     = WRITE;
      end
      WRITE: begin
        bus.cpu_stall     = 1'b1;
        bus.spram_wr_en   = 1'b1;
        bus.spram_wr_addr = dst_addr;
        state_nxt         = (idx == 8'hFF) ? DONE : READ;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: doc/sprite_dma.md
# sprite_dma

Sprite-attribute DMA engine feeding the sprite RAM (SPRAM) consumed by `ppu_fsm`. It snoops CPU bus writes; a write to $4014 copies the 256-byte CPU page $XX00–$XXFF into SPRAM while stalling the CPU. SPRAM is written starting at the OAM address latched from $2003, wrapping mod 256. It sits between the CPU bus / work RAM read port and the SPRAM write port of the `generic_ram` instance.

## Interface
- `DMA_REG`, 16'h4014, CPU address that triggers a transfer; written data is the source page.
- `OAM_ADDR_REG`, 16'h2003, CPU address that loads the SPRAM start offset.
- `clk` in 1, single clock; all logic rising-edge.
- `rst` in 1, synchronous, active-high reset.
- `cpu_wr_en` in 1, CPU bus write strobe, one cycle per write.
- `cpu_wr_addr` in 16, CPU bus write address.
- `cpu_wr_data` in 8, CPU bus write data.
- `mem_rd_addr` out 16, registered read address to CPU work memory. The memory is synchronous: data appears one cycle later.
- `mem_rd_data` in 8, read data for the address presented in the previous cycle.
- `spram_wr_en` out 1, SPRAM write strobe.
- `spram_wr_addr` out 8, SPRAM write address.
- `spram_wr_data` out 8, SPRAM write data; a combinational pass-through of `mem_rd_data`.
- `cpu_stall` out 1, halts the CPU while high.
- `busy` out 1, high in any state other than IDLE.
- `done` out 1, one-cycle pulse after the final SPRAM write.

## Operation
- Registers:
  - `page[7:0]` and `oam_addr[7:0]`.
  - `idx[7:0]`: transfer byte counter.
  - `parity`: free-running bit, 0 after reset, toggles every clock.
- `oam_addr` loads `cpu_wr_data` on `cpu_wr_en && cpu_wr_addr==OAM_ADDR_REG`, in IDLE only.
- Trigger: `cpu_wr_en && cpu_wr_addr==DMA_REG` while in IDLE.
  - Latches `page=cpu_wr_data`, clears `idx`, next state HALT.
- FSM states:
  - IDLE: waits for trigger.
  - HALT: one cycle. Next state ALIGN if `parity==1` in this cycle, otherwise READ.
  - ALIGN: one dummy cycle, then READ.
  - READ: drives `mem_rd_addr={page,idx}`, then WRITE.
  - WRITE: drives `spram_wr_en=1`, `spram_wr_addr=oam_addr+idx` (8-bit, wraps), `spram_wr_data=mem_rd_data`.
    - If `idx==255`: next state DONE.
    - Else: `idx<=idx+1`, next state READ.
  - DONE: `done=1` for one cycle, then IDLE.
- `cpu_stall`=1 in HALT, ALIGN, READ and WRITE; it is 0 in DONE and IDLE.
- `busy`=1 in every state except IDLE.
- `oam_addr` is not modified by a transfer.
- Writes to the trigger or OAM register while not IDLE are ignored, including a re-trigger.
- Page wrap: the source address never crosses the page; it is always `{page,idx}`.
- Reset takes effect in any state, including mid-transfer:
  - state IDLE; `page`, `oam_addr`, `idx`, `parity` = 0.
  - Partial SPRAM contents are left as-is.
- Reset value of every output: `mem_rd_addr`=0, `spram_wr_en`=0, `spram_wr_addr`=0, `cpu_stall`=0, `busy`=0, `done`=0.
  - `spram_wr_data` follows `mem_rd_data`.

## Timing
- Trigger write sampled at edge T; HALT is the cycle after T. `cpu_stall` and `busy` rise in the cycle after T.
- Read to write: the address is presented in READ cycle k. The data is consumed in WRITE cycle k+1, through the memory's one-cycle latency.
- Transfer length: 256 READ/WRITE pairs = 512 cycles.
- Stall duration: 513 cycles when `parity` is 0 in HALT; 514 cycles when it is 1.
- `done` is asserted in the cycle after the last WRITE, when `cpu_stall` is already 0.
- `spram_wr_en` is high only in WRITE cycles: exactly 256 strobes per transfer, never back-to-back.
- Earliest re-trigger: the cycle after DONE, i.e. when IDLE is observed.

## Test plan
- Even-aligned transfer:
  - Stimulus: write $00 to $2003, then $02 to $4014 with `parity` 0 in HALT.
  - Required response: SPRAM[i] = mem[$0200+i] for i=0..255; `cpu_stall` high for exactly 513 cycles; one `done` pulse.
- Odd-aligned transfer: same stimulus with `parity` 1 in HALT -> ALIGN inserted; stall lasts 514 cycles; SPRAM contents identical to the even case.
- OAM offset wrap: $2003=$F0, $4014=$03 -> SPRAM[$F0]=mem[$0300], SPRAM[$FF]=mem[$030F], SPRAM[$00]=mem[$0310], SPRAM[$EF]=mem[$03FF]. `oam_addr` is still $F0 after the transfer.
- Ignored writes: a $4014 write and a $2003 write issued at idx=100 -> `page` and `oam_addr` unchanged; transfer completes with 256 writes.
- Reset mid-transfer: assert `rst` at idx=50.
  - Next cycle: all outputs 0, `busy`=0.
  - SPRAM[0..49] hold the copied bytes; SPRAM[50..255] are untouched.
  - A new trigger then runs normally.
- Strobe timing: check `spram_wr_addr`/`spram_wr_data` against `mem_rd_addr` delayed one cycle, every WRITE. `spram_wr_en` is never high in IDLE, HALT, ALIGN or DONE.
